switch_merge: RTL and testbench
===============================

# switch_merge

Two-to-one merge for the address-routed switch fabric: accepts beats from port A (low address range) and port B (high address range), buffers each in its own FIFO, and forwards them onto a single valid/ready output stream with fair round-robin arbitration. It is the return-path counterpart of the one-to-two address switch: it recombines the split A/B traffic into one stream, preserving per-port order.

## Interface
- ADDR_WIDTH, 8, address width of all ports
- DATA_WIDTH, 16, data width of all ports
- FIFO_DEPTH, 4, entries per input FIFO; power of two, >= 2
- ADDR_DIV, 8'h3F, highest port-A address; used only by the address check (see Configuration)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- vld_a  input  1  port A beat valid
- addr_a  input  ADDR_WIDTH  port A address
- data_a  input  DATA_WIDTH  port A data
- rdy_a  output  1  port A ready
- vld_b  input  1  port B beat valid
- addr_b  input  ADDR_WIDTH  port B address
- data_b  input  DATA_WIDTH  port B data
- rdy_b  output  1  port B ready
- vld  output  1  merged output valid
- addr  output  ADDR_WIDTH  merged output address
- data  output  DATA_WIDTH  merged output data
- rdy  input  1  downstream ready
- drop_cnt  output  8  saturating count of dropped beats

## Operation
- Input acceptance: a beat on port X is accepted at a rising edge where vld_X && rdy_X; it is written to FIFO X.
- rdy_X = ready-enable flop && !full_X. The ready-enable flop resets to 0 and sets to 1 at the first rising edge after rstn deasserts. A full FIFO does not accept, even if it is popped in the same cycle.
- Output register: vld/addr/data are registered. The register loads when it is empty (!vld) or is being consumed (vld && rdy).
- Arbitration at each load opportunity:
  - Both FIFOs non-empty: the port selected by the round-robin pointer wins.
  - One FIFO non-empty: that port wins.
  - Pointer update: after every grant, the pointer moves to the non-winning port.
  - Pointer reset value: favours A.
- Output register with no FIFO data at a load opportunity: vld clears to 0. addr/data hold their last value.
- Ordering: per-port order is preserved. There is no ordering guarantee across ports beyond round-robin.
- FIFO pointers: log2(FIFO_DEPTH) bits plus one wrap bit. Full when the indices are equal and the wrap bits differ. Empty when the pointers are equal. Wrap-around is by natural binary overflow.
- Total buffering per port: FIFO_DEPTH entries plus the shared output register.
- Reset (asynchronous, any time, including mid-transfer):
  - vld=0, addr=0, data=0, rdy_a=0, rdy_b=0, drop_cnt=0.
  - FIFOs empty, pointer=A.
  - In-flight beats are discarded.

## Timing
- Minimum latency: a beat accepted at edge E0 into an empty FIFO with an empty/draining output register appears with vld=1 after edge E1.
- Throughput: one output beat per cycle while rdy=1 and any FIFO is non-empty; each port sustains one beat per cycle.
- While vld && !rdy: vld, addr and data remain stable until the edge where rdy=1.
- rdy_X depends only on registered state. There is no combinational path from vld_X or rdy to rdy_X.
- Simultaneous push and pop on a non-full FIFO: both occur; occupancy is unchanged.

## Configuration
- SWITCH_MERGE_ADDR_CHECK_EN defined:
  - A port-A beat with addr_a > ADDR_DIV is dropped.
  - A port-B beat with addr_b <= ADDR_DIV is dropped.
  - "Dropped" means the beat is accepted (the handshake completes) but is not written to the FIFO.
  - drop_cnt increments by 1 per dropped beat and saturates at 8'hFF. Drops on both ports in the same cycle add 2, also saturating.
- Not defined: all accepted beats are forwarded, the check logic is absent, and drop_cnt is tied to 0.

## Test plan
- Reset: assert rstn low asynchronously mid-stream with 3 beats buffered -> vld=0, addr=0, data=0, rdy_a=rdy_b=0 immediately. After release: rdy_a=rdy_b=1 one edge later, and no stale beat appears.
- Single beat: A sends addr 8'h10 / data 16'h1234 with rdy=1 -> vld=1 with 8'h10/16'h1234 exactly one cycle after acceptance, then vld=0.
- Fairness: A streams addrs 8'h01, 8'h02, 8'h03 and B streams 8'h80, 8'h81, 8'h82 starting in the same cycle, rdy=1 -> output order is 01, 80, 02, 81, 03, 82.
- Backpressure: rdy=0 with A pushing continuously, FIFO_DEPTH=4 -> 5 beats accepted (4 in the FIFO plus the output register), then rdy_a=0. The output holds the first beat stable. Then set rdy=1 -> all 5 beats drain in order, 1 per cycle, and rdy_a reasserts one cycle after the first pop.
- Address check: A sends addr 8'h40 and B sends 8'h3F in the same cycle. With SWITCH_MERGE_ADDR_CHECK_EN: both are accepted, neither is output, and drop_cnt=2. Without the macro: both are output (A first) and drop_cnt=0.
- Saturation (macro on): 300 illegal beats -> drop_cnt stops at 8'hFF.

Source files
------------

// File: rtl/switch_merge.sv
// switch_merge: two-to-one merge for the address-routed switch fabric return path.
// Port A and port B beats are each buffered in their own FIFO and forwarded onto a
// single registered valid/ready stream using round-robin arbitration (reset favours A).
// Per-port order is preserved.
//
// Optional feature macro: SWITCH_MERGE_ADDR_CHECK_EN
//   defined   : port-A beats with addr_a > ADDR_DIV and port-B beats with
//               addr_b <= ADDR_DIV are accepted but discarded, and counted in the
//               saturating drop_cnt.
//   undefined : every accepted beat is forwarded and drop_cnt is tied to 0.
module switch_merge #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned ADDR_DIV   = 32'h3F
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  vld_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  rdy_a,
  input  logic                  vld_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  rdy_b,
  output logic                  vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  rdy,
  output logic [7:0]            drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int PA = 0;
  localparam int PB = 1;

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("switch_merge: FIFO_DEPTH must be a power of two >= 2");
  end
  if (ADDR_WIDTH < 32 && ADDR_DIV >= (32'd1 << ADDR_WIDTH)) begin : g_bad_div
    $error("switch_merge: ADDR_DIV does not fit in ADDR_WIDTH");
  end

  logic                  en_q, en_d;
  logic [AW:0]           wr_ptr_q [2];
  logic [AW:0]           wr_ptr_d [2];
  logic [AW:0]           rd_ptr_q [2];
  logic [AW:0]           rd_ptr_d [2];
  logic [EW-1:0]         mem_q [2][FIFO_DEPTH];
  logic [EW-1:0]         in_beat [2];
  logic [EW-1:0]         head [2];
  logic [1:0]            in_vld, in_acc, drop, push, pop, full, empty;
  logic                  rr_q, rr_d;      // 0: A has priority, 1: B has priority
  logic                  vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  load, any_avail, grant_b;

  // Ready-enable goes high on the first edge after reset release and stays there.
  assign en_d = 1'b1;

  // FIFO status and head-of-queue lookup, from registered pointers only.
  always_comb begin
    in_vld      = {vld_b, vld_a};
    in_beat[PA] = {addr_a, data_a};
    in_beat[PB] = {addr_b, data_b};
    for (int i = 0; i < 2; i++) begin
      full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                 (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      head[i]  = mem_q[i][rd_ptr_q[i][AW-1:0]];
    end
  end

  // A full FIFO refuses beats even when it is being popped this cycle, which keeps
  // rdy_X purely registered.
  assign rdy_a  = en_q && !full[PA];
  assign rdy_b  = en_q && !full[PB];
  assign in_acc = in_vld & {rdy_b, rdy_a};

`ifdef SWITCH_MERGE_ADDR_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] DIV = ADDR_WIDTH'(ADDR_DIV);

  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [8:0] drop_sum;

  // A beat landing on the wrong side of the address split completes its handshake but is discarded.
  assign drop = {in_acc[PB] && (addr_b <= DIV), in_acc[PA] && (addr_a > DIV)};

  // Drop counter adds up to two per cycle and sticks at 8'hFF.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + {8'd0, drop[PA]} + {8'd0, drop[PB]};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drop_cnt_q <= 8'h00;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop     = 2'b00;
  assign drop_cnt = 8'h00;
`endif

  assign push = in_acc & ~drop;

  // Round-robin arbitration into the output register plus FIFO pointer advance.
  always_comb begin
    load      = !vld_q || rdy;
    any_avail = !(empty[PA] && empty[PB]);
    if (!empty[PA] && !empty[PB]) grant_b = rr_q;
    else                          grant_b = empty[PA];
    pop    = 2'b00;
    rr_d   = rr_q;
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load) begin
      vld_d = any_avail;
      if (any_avail) begin
        pop              = grant_b ? 2'b10 : 2'b01;
        {addr_d, data_d} = head[grant_b];
        rr_d             = !grant_b;
      end
    end
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push[i]};
      rd_ptr_d[i] = rd_ptr_q[i] + {{AW{1'b0}}, pop[i]};
    end
  end

  // Control state and output register; reset discards anything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q         <= 1'b0;
      rr_q         <= 1'b0;
      vld_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_ptr_q[PA] <= '0;
      wr_ptr_q[PB] <= '0;
      rd_ptr_q[PA] <= '0;
      rd_ptr_q[PB] <= '0;
    end else begin
      en_q         <= en_d;
      rr_q         <= rr_d;
      vld_q        <= vld_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_ptr_q[PA] <= wr_ptr_d[PA];
      wr_ptr_q[PB] <= wr_ptr_d[PB];
      rd_ptr_q[PA] <= rd_ptr_d[PA];
      rd_ptr_q[PB] <= rd_ptr_d[PB];
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push[PA]) mem_q[PA][wr_ptr_q[PA][AW-1:0]] <= in_beat[PA];
    if (push[PB]) mem_q[PB][wr_ptr_q[PB][AW-1:0]] <= in_beat[PB];
  end

  assign vld  = vld_q;
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: tb/tb_switch_merge.sv
// Directed bench for switch_merge: reset, single beat, fairness, backpressure,
// address check (both builds) and drop-counter saturation (macro build).
module tb_switch_merge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vld_a, vld_b, rdy_a, rdy_b, vld, rdy;
  logic [7:0]  addr_a, addr_b, addr, drop_cnt;
  logic [15:0] data_a, data_b, data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          k;
  int          n_acc;
  logic        acc;

  logic [7:0]  fair_addr_exp [6] = '{8'h01, 8'h80, 8'h02, 8'h81, 8'h03, 8'h82};
  logic [15:0] fair_data_exp [6] = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002, 16'hB002};

  switch_merge dut (
    .clk      (clk),
    .rstn     (rstn),
    .vld_a    (vld_a),
    .addr_a   (addr_a),
    .data_a   (data_a),
    .rdy_a    (rdy_a),
    .vld_b    (vld_b),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .rdy_b    (rdy_b),
    .vld      (vld),
    .addr     (addr),
    .data     (data),
    .rdy      (rdy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vld_a  = 1'b0;
    vld_b  = 1'b0;
    addr_a = 8'h00;
    addr_b = 8'h00;
    data_a = 16'h0000;
    data_b = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rdy = 1'b0;

    // reset values
    #2;
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_rdy_a", 32'(rdy_a), 32'd0);
    chk("rst_rdy_b", 32'(rdy_b), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    #10;
    rstn = 1'b1;
    chk("rel_rdy_a_pre", 32'(rdy_a), 32'd0);
    tick();
    chk("rel_rdy_a", 32'(rdy_a), 32'd1);
    chk("rel_rdy_b", 32'(rdy_b), 32'd1);

    // fairness: both ports stream three beats starting the same cycle
    rdy = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) begin
        vld_a  = 1'b1;
        addr_a = 8'(8'h01 + i);
        data_a = 16'(16'hA000 + i);
        vld_b  = 1'b1;
        addr_b = 8'(8'h80 + i);
        data_b = 16'(16'hB000 + i);
      end else begin
        vld_a = 1'b0;
        vld_b = 1'b0;
      end
      tick();
      if (vld) begin
        if (k < 6) begin
          chk("fair_addr", 32'(addr), 32'(fair_addr_exp[k]));
          chk("fair_data", 32'(data), 32'(fair_data_exp[k]));
        end
        k++;
      end
    end
    chk("fair_count", 32'(k), 32'd6);

    // single beat latency
    do_reset();
    rdy    = 1'b1;
    vld_a  = 1'b1;
    addr_a = 8'h10;
    data_a = 16'h1234;
    tick();
    vld_a = 1'b0;
    chk("single_lat0_vld", 32'(vld), 32'd0);
    tick();
    chk("single_vld", 32'(vld), 32'd1);
    chk("single_addr", 32'(addr), 32'h10);
    chk("single_data", 32'(data), 32'h1234);
    tick();
    chk("single_after_vld", 32'(vld), 32'd0);
    chk("single_hold_addr", 32'(addr), 32'h10);

    // backpressure: output stalled, A pushes continuously
    do_reset();
    rdy   = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      vld_a  = 1'b1;
      addr_a = 8'(8'h20 + n_acc);
      data_a = 16'(16'hC000 + n_acc);
      acc    = rdy_a;
      tick();
      if (acc) n_acc++;
      if (i >= 1) begin
        chk("bp_hold_vld", 32'(vld), 32'd1);
        chk("bp_hold_addr", 32'(addr), 32'h20);
      end
    end
    chk("bp_accepted", 32'(n_acc), 32'd5);
    chk("bp_rdy_a_low", 32'(rdy_a), 32'd0);
    chk("bp_hold_data", 32'(data), 32'hC000);
    vld_a = 1'b0;
    rdy   = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      if (i == 1) chk("bp_rdy_a_back", 32'(rdy_a), 32'd1);
      chk("bp_drain_vld", 32'(vld), 32'd1);
      chk("bp_drain_addr", 32'(addr), 32'(8'h20 + i));
      chk("bp_drain_data", 32'(data), 32'(16'hC000 + i));
    end
    tick();
    chk("bp_drain_done", 32'(vld), 32'd0);

    // address check: A sends 8'h40, B sends 8'h3F in the same cycle
    do_reset();
    rdy    = 1'b1;
    vld_a  = 1'b1;
    addr_a = 8'h40;
    data_a = 16'h1111;
    vld_b  = 1'b1;
    addr_b = 8'h3F;
    data_b = 16'h2222;
    acc    = rdy_a & rdy_b;
    tick();
    vld_a = 1'b0;
    vld_b = 1'b0;
    chk("ac_accepted", 32'(acc), 32'd1);
`ifdef SWITCH_MERGE_ADDR_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ac_no_out", 32'(vld), 32'd0);
    end
    chk("ac_drop_cnt", 32'(drop_cnt), 32'd2);
`else
    tick();
    chk("ac_a_vld", 32'(vld), 32'd1);
    chk("ac_a_addr", 32'(addr), 32'h40);
    chk("ac_a_data", 32'(data), 32'h1111);
    tick();
    chk("ac_b_vld", 32'(vld), 32'd1);
    chk("ac_b_addr", 32'(addr), 32'h3F);
    chk("ac_b_data", 32'(data), 32'h2222);
    tick();
    chk("ac_end_vld", 32'(vld), 32'd0);
    chk("ac_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // asynchronous reset with three beats buffered
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld_a  = 1'b1;
      addr_a = 8'(8'h50 + i);
      data_a = 16'(16'h5000 + i);
      tick();
    end
    vld_a = 1'b0;
    chk("mid_pre_vld", 32'(vld), 32'd1);
    chk("mid_pre_addr", 32'(addr), 32'h50);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(vld), 32'd0);
    chk("mid_rst_addr", 32'(addr), 32'd0);
    chk("mid_rst_data", 32'(data), 32'd0);
    chk("mid_rst_rdy_a", 32'(rdy_a), 32'd0);
    chk("mid_rst_rdy_b", 32'(rdy_b), 32'd0);
    rstn = 1'b1;
    rdy  = 1'b1;
    tick();
    chk("mid_rel_rdy_a", 32'(rdy_a), 32'd1);
    chk("mid_rel_rdy_b", 32'(rdy_b), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", 32'(vld), 32'd0);
    end

`ifdef SWITCH_MERGE_ADDR_CHECK_EN
    // drop counter saturation with 300 illegal port-A beats
    do_reset();
    rdy    = 1'b1;
    vld_a  = 1'b1;
    addr_a = 8'hC0;
    data_a = 16'h0BAD;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) chk("sat_mid", 32'(drop_cnt), 32'd100);
    end
    vld_a = 1'b0;
    chk("sat_cnt", 32'(drop_cnt), 32'hFF);
    chk("sat_no_out", 32'(vld), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
